// File: rtl/fixed_point_divider_param_if.sv
// fixed_point_divider_param_if
// Groups the request/result signals of the fixed-point divider.
//   start        request, honoured only while the divider is idle
//   signed_mode  0 = unsigned operands, 1 = two's-complement operands
//   A, B         dividend and divisor (W bits, FRAC fraction bits)
//   Q, R         quotient and remainder (W bits)
//   busy         high while an operation is in flight
//   done         one-cycle pulse when Q/R/ov/dvz are updated
//   ov           quotient not representable in W bits
//   dvz          divide by zero
// master: the requester side. slave: the divider side.
interface fixed_point_divider_param_if #(
  parameter int W = 10
);
  logic         start;
  logic         signed_mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         ov;
  logic         dvz;

  modport master (
    output start, signed_mode, A, B,
    input  Q, R, busy, done, ov, dvz
  );

  modport slave (
    input  start, signed_mode, A, B,
    output Q, R, busy, done, ov, dvz
  );
endinterface

// File: rtl/fixed_point_divider_param.sv
// fixed_point_divider_param
// Multi-cycle restoring divider for fixed-point operands that share FRAC
// fraction bits. The magnitude of the dividend is pre-shifted by FRAC so
// the quotient keeps the operands' fixed-point format. One quotient bit
// is produced per cycle over N = W + FRAC cycles.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-low reset
//   bus  slave modport of fixed_point_divider_param_if
//        (start, signed_mode, A, B in; Q, R, busy, done, ov, dvz out)
// Parameters:
//   W     operand/result width
//   FRAC  fraction bits, 0 <= FRAC < W
//   SAT   1 = saturate Q on overflow, 0 = keep low W bits of the result
module fixed_point_divider_param #(
  parameter int W    = 10,
  parameter int FRAC = 4,
  parameter int SAT  = 1
) (
  input logic                        clk,
  input logic                        rst,
  fixed_point_divider_param_if.slave bus
);

  localparam int N  = W + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
  localparam logic [W-1:0]  ALL_ONES  = '1;
  localparam logic [W-1:0]  POS_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  NEG_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic [N-1:0]  POS_LIMIT = N'(POS_MAX);
  localparam logic [N-1:0]  NEG_LIMIT = N'(NEG_MIN);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W:0]    acc;
  // Holds the shifted dividend; quotient bits enter at the LSB, so after
  // N steps this register is the raw N-bit quotient.
  logic [N-1:0]  dvd;
  logic [W-1:0]  mag_b;
  logic          neg_q;
  logic          neg_r;
  logic          sgn;
  logic          dz;

  logic          sign_a;
  logic          sign_b;
  logic [W-1:0]  mag_a_in;
  logic [W-1:0]  mag_b_in;
  logic [W:0]    acc_shift;
  logic [W:0]    acc_diff;
  logic          fits;
  logic [W-1:0]  q_low;
  logic [W-1:0]  q_signed;
  logic [W-1:0]  q_sat;
  logic [W-1:0]  r_signed;
  logic          ovf;

  // Operand magnitudes, the restoring step and the final result shaping.
  // In unsigned mode the sign bits are forced to zero so the operands pass
  // through untouched and neither result is negated.
  always_comb begin
    sign_a    = bus.signed_mode & bus.A[W-1];
    sign_b    = bus.signed_mode & bus.B[W-1];
    mag_a_in  = sign_a ? -bus.A : bus.A;
    mag_b_in  = sign_b ? -bus.B : bus.B;

    // The remainder is always below |B|, so acc never carries into its top
    // bit between steps; shifting the whole register keeps that invariant.
    acc_shift = (acc << 1) | (W+1)'(dvd[N-1]);
    acc_diff  = acc_shift - {1'b0, mag_b};
    fits      = acc_shift >= {1'b0, mag_b};

    q_low     = dvd[W-1:0];
    q_signed  = neg_q ? -q_low : q_low;
    q_sat     = sgn ? (neg_q ? NEG_MIN : POS_MAX) : ALL_ONES;
    r_signed  = neg_r ? -acc[W-1:0] : acc[W-1:0];

    // Unsigned: anything above the low W bits overflows. Signed: the
    // negative range reaches one further than the positive range.
    if (sgn) begin
      ovf = dvd > (neg_q ? NEG_LIMIT : POS_LIMIT);
    end else begin
      ovf = (dvd >> W) != '0;
    end
  end

  // Control FSM and datapath registers. A zero divisor skips the iteration
  // phase entirely and goes straight to FIN, which publishes the saturated
  // quotient. All outputs are registered; done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dvd      <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sgn      <= 1'b0;
      dz       <= 1'b0;
      bus.Q    <= '0;
      bus.R    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ov   <= 1'b0;
      bus.dvz  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mag_b    <= mag_b_in;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            sgn      <= bus.signed_mode;
            dvd      <= N'(mag_a_in) << FRAC;
            acc      <= '0;
            cnt      <= '0;
            dz       <= (bus.B == '0);
            bus.busy <= 1'b1;
            state    <= (bus.B == '0) ? FIN : ITER;
          end
        end
        ITER: begin
          acc <= fits ? acc_diff : acc_shift;
          dvd <= {dvd[N-2:0], fits};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state <= FIN;
          end
        end
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
          if (dz) begin
            bus.Q   <= q_sat;
            bus.R   <= '0;
            bus.ov  <= 1'b0;
            bus.dvz <= 1'b1;
          end else begin
            bus.Q   <= (ovf && SAT != 0) ? q_sat : q_signed;
            bus.R   <= r_signed;
            bus.ov  <= ovf;
            bus.dvz <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider_param.sv
// tb_fixed_point_divider_param
// Drives a saturating (SAT=1) and a wrapping (SAT=0) divider with identical
// stimulus. Each accepted request pushes its expected result, derived from
// integer arithmetic, onto a scoreboard queue; a monitor pops and compares
// on every done pulse, including the edge at which done arrives.
module tb_fixed_point_divider_param;

  localparam int W    = 10;
  localparam int FRAC = 4;
  localparam int N    = W + FRAC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int asserts  = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fixed_point_divider_param_if #(.W(W)) bus_sat ();
  fixed_point_divider_param_if #(.W(W)) bus_wrap ();

  fixed_point_divider_param #(.W(W), .FRAC(FRAC), .SAT(1)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  fixed_point_divider_param #(.W(W), .FRAC(FRAC), .SAT(0)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_wrap)
  );

  typedef struct {
    logic [W-1:0] q_sat;
    logic [W-1:0] q_wrap;
    logic [W-1:0] r;
    logic         ov;
    logic         dvz;
    int           done_edge;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    asserts++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference result from plain integer division of (|A| << FRAC) by |B|.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm, input string tag, input int k);
    exp_t         e;
    int           ma, mb, quo, rem, res;
    logic         nq, nr;
    logic [W-1:0] sat_val;
    nr = sm && a[W-1];
    nq = sm && (a[W-1] ^ b[W-1]);
    ma = nr ? (1 << W) - int'(a) : int'(a);
    mb = (sm && b[W-1]) ? (1 << W) - int'(b) : int'(b);
    if (!sm)     sat_val = '1;
    else if (nq) sat_val = W'(1 << (W-1));
    else         sat_val = W'((1 << (W-1)) - 1);
    e.name = tag;
    if (b == '0) begin
      e.dvz       = 1'b1;
      e.ov        = 1'b0;
      e.r         = '0;
      e.q_sat     = sat_val;
      e.q_wrap    = sat_val;
      e.done_edge = k + 1;
    end else begin
      quo = (ma << FRAC) / mb;
      rem = (ma << FRAC) % mb;
      if (!sm)     e.ov = quo > (1 << W) - 1;
      else if (nq) e.ov = quo > (1 << (W-1));
      else         e.ov = quo > (1 << (W-1)) - 1;
      res         = nq ? -quo : quo;
      e.q_wrap    = W'(res);
      e.q_sat     = e.ov ? sat_val : e.q_wrap;
      e.r         = W'(nr ? -rem : rem);
      e.dvz       = 1'b0;
      e.done_edge = k + N + 1;
    end
    return e;
  endfunction

  task automatic driveBoth(input logic st, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sm);
    bus_sat.start        = st;
    bus_sat.A            = a;
    bus_sat.B            = b;
    bus_sat.signed_mode  = sm;
    bus_wrap.start       = st;
    bus_wrap.A           = a;
    bus_wrap.B           = b;
    bus_wrap.signed_mode = sm;
  endtask

  // Called between edges while the divider is idle; start is sampled on the
  // next rising edge (edge k). Operands are scrambled after acceptance.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sm, input string tag, output int k);
    driveBoth(1'b1, a, b, sm);
    k = cyc + 1;
    sb.push_back(model(a, b, sm, tag, k));
    @(negedge clk);
    driveBoth(1'b0, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic waitDone(input string tag);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < N + 10) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (sb.size() != 0) begin
      checkOutput({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic waitEdge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic runOne(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input string tag);
    int k;
    applyStimulus(a, b, sm, tag, k);
    waitDone(tag);
  endtask

  // Scoreboard monitor: compares both instances on each done pulse.
  always @(negedge clk) begin
    if (bus_sat.done || bus_wrap.done) begin
      checkOutput("done_align", 32'(bus_wrap.done), 32'(bus_sat.done));
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'(bus_sat.done | bus_wrap.done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_edge"},   32'(cyc),          32'(mon_e.done_edge));
        checkOutput({mon_e.name, "_q"},      32'(bus_sat.Q),    32'(mon_e.q_sat));
        checkOutput({mon_e.name, "_q_wrap"}, 32'(bus_wrap.Q),   32'(mon_e.q_wrap));
        checkOutput({mon_e.name, "_r"},      32'(bus_sat.R),    32'(mon_e.r));
        checkOutput({mon_e.name, "_r_wrap"}, 32'(bus_wrap.R),   32'(mon_e.r));
        checkOutput({mon_e.name, "_ov"},     32'(bus_sat.ov),   32'(mon_e.ov));
        checkOutput({mon_e.name, "_ov_wrap"},32'(bus_wrap.ov),  32'(mon_e.ov));
        checkOutput({mon_e.name, "_dvz"},    32'(bus_sat.dvz),  32'(mon_e.dvz));
        checkOutput({mon_e.name, "_busy"},   32'(bus_sat.busy), 32'd0);
      end
    end
  end

  initial begin
    int k;
    logic [W-1:0] ra, rb;
    logic rs;

    driveBoth(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_q",    32'(bus_sat.Q),    32'd0);
    checkOutput("reset_r",    32'(bus_sat.R),    32'd0);
    checkOutput("reset_busy", 32'(bus_sat.busy), 32'd0);
    checkOutput("reset_done", 32'(bus_sat.done), 32'd0);
    checkOutput("reset_ov",   32'(bus_sat.ov),   32'd0);
    checkOutput("reset_dvz",  32'(bus_sat.dvz),  32'd0);
    checkOutput("reset_q_wrap", 32'(bus_wrap.Q), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    runOne(10'd48,  10'd32,  1'b0, "u48_32");
    runOne(10'd16,  10'd48,  1'b0, "u16_48");
    runOne(10'h3FF, 10'd1,   1'b0, "u_ovf");
    runOne(10'd123, 10'd0,   1'b0, "u_dvz");
    runOne(10'h3D0, 10'd0,   1'b1, "s_dvz");
    runOne(10'h3D0, 10'd32,  1'b1, "s_nega");
    runOne(10'd48,  10'h3E0, 1'b1, "s_negb");
    runOne(10'h3D0, 10'h3E0, 1'b1, "s_negab");
    runOne(10'h200, 10'd1,   1'b1, "s_min_ovf");
    runOne(10'd32,  10'd1,   1'b1, "s_pos_edge");
    runOne(10'h3E0, 10'd1,   1'b1, "s_neg_edge");
    runOne(10'd31,  10'd1,   1'b1, "s_pos_max");
    runOne(10'd0,   10'd7,   1'b0, "u_zero");

    // start pulsed mid-operation must be ignored
    applyStimulus(10'd48, 10'd32, 1'b0, "ignore_busy", k);
    waitEdge(k + 2);
    #1;
    checkOutput("ignore_busy_flag", 32'(bus_sat.busy), 32'd1);
    driveBoth(1'b1, 10'd1, 10'd3, 1'b1);
    @(negedge clk);
    driveBoth(1'b0, 10'd1, 10'd3, 1'b1);
    waitDone("ignore_busy");

    // start during FIN must be ignored
    applyStimulus(10'd100, 10'd7, 1'b0, "ignore_fin", k);
    waitEdge(k + N);
    driveBoth(1'b1, 10'd5, 10'd3, 1'b0);
    @(negedge clk);
    driveBoth(1'b0, 10'd5, 10'd3, 1'b0);
    waitDone("ignore_fin");
    repeat (N + 4) @(negedge clk);
    #1;
    checkOutput("ignore_fin_idle", 32'(bus_sat.busy), 32'd0);

    // reset at edge k+5 aborts the operation with no done pulse
    applyStimulus(10'd48, 10'd32, 1'b0, "abort", k);
    waitEdge(k + 4);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    #1;
    checkOutput("abort_q",    32'(bus_sat.Q),    32'd0);
    checkOutput("abort_r",    32'(bus_sat.R),    32'd0);
    checkOutput("abort_busy", 32'(bus_sat.busy), 32'd0);
    checkOutput("abort_done", 32'(bus_sat.done), 32'd0);
    checkOutput("abort_q_wrap", 32'(bus_wrap.Q), 32'd0);
    rst = 1'b1;
    repeat (N + 5) @(negedge clk);
    #1;
    checkOutput("abort_still_idle", 32'(bus_sat.busy), 32'd0);

    // back-to-back: second start in the cycle right after done
    runOne(10'd48, 10'd32, 1'b0, "b2b_first");
    runOne(10'd200, 10'd9, 1'b0, "b2b_second");

    // random mixed stream, back-to-back
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rs = 1'($urandom);
      runOne(ra, rb, rs, $sformatf("rnd%0d", i));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
